// File: rtl/prog_fetch.sv
// prog_fetch: program counter and instruction fetch stage.
//   Fetches two bytes per instruction from a byte-wide combinational ROM.
//   The opcode is at the even byte and the operand is at the odd byte.
//   The two bytes are assembled into {opcode, operand* and passed to the
//   decoder through a one-entry valid/ready output register.
//   A jump from the execute side reloads the PC and flushes any partial or
//   held word.
//
// Ports:
//   clk         system clock, rising edge
//   nReset      synchronous active-low reset
//   rom_addr    ROM byte address = {pc, phase}
//   rom_data    ROM byte for rom_addr, same cycle
//   inst_word   assembled instruction {opcode, operand}
//   inst_pc     word address of inst_word
//   inst_valid  inst_word/inst_pc hold an unconsumed instruction
//   inst_ready  decoder accepts (transfer on inst_valid & inst_ready)
//   jump_en     load PC from jump_addr (single-cycle pulse)
//   jump_addr   jump target, word address
//
// state    | meaning
// FETCH_HI | rom_addr points at the opcode byte; capture it into hi_byte
// FETCH_LO | rom_addr points at the operand byte; load output slot when free
module prog_fetch #(
  parameter int ADDR_W = 8,
  parameter logic [ADDR_W-2:0] RESET_VEC = '0
) (
  input  logic              clk,
  input  logic              nReset,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [7:0]        rom_data,
  output logic [15:0]       inst_word,
  output logic [ADDR_W-2:0] inst_pc,
  output logic              inst_valid,
  input  logic              inst_ready,
  input  logic              jump_en,
  input  logic [ADDR_W-2:0] jump_addr
);

  typedef enum logic {
    FETCH_HI = 1'b0,
    FETCH_LO = 1'b1
  } state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-2:0] pc, pc_nxt;
  logic [7:0]        hi_byte, hi_byte_nxt;
  logic [15:0]       inst_word_nxt;
  logic [ADDR_W-2:0] inst_pc_nxt;
  logic              inst_valid_nxt;
  logic              slot_free;

  assign rom_addr  = {pc, (state == FETCH_LO)};
  assign slot_free = !inst_valid || inst_ready;

  always_ff @(posedge clk) begin
    if (!nReset) begin
      state      <= FETCH_HI;
      pc         <= RESET_VEC;
      hi_byte    <= 8'h00;
      inst_word  <= 16'h0000;
      inst_pc    <= '0;
      inst_valid <= 1'b0;
    end else begin
      state      <= state_nxt;
      pc         <= pc_nxt;
      hi_byte    <= hi_byte_nxt;
      inst_word  <= inst_word_nxt;
      inst_pc    <= inst_pc_nxt;
      inst_valid <= inst_valid_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    pc_nxt         = pc;
    hi_byte_nxt    = hi_byte;
    inst_word_nxt  = inst_word;
    inst_pc_nxt    = inst_pc;
    inst_valid_nxt = inst_valid;

    // A transfer empties the slot unless a new word is loaded below.
    if (inst_valid && inst_ready) begin
      inst_valid_nxt = 1'b0;
    end

    if (jump_en) begin
      // Jump beats fetch and stall. A same-cycle transfer has already been
      // taken by the decoder. The held word and hi_byte are discarded.
      pc_nxt         = jump_addr;
      state_nxt      = FETCH_HI;
      inst_valid_nxt = 1'b0;
    end else begin
      unique case (state)
        FETCH_HI: begin
          hi_byte_nxt = rom_data;
          state_nxt   = FETCH_LO;
        end
        FETCH_LO: begin
          if (slot_free) begin
            inst_word_nxt  = {hi_byte, rom_data};
            inst_pc_nxt    = pc;
            inst_valid_nxt = 1'b1;
            pc_nxt         = pc + 1'b1;
            state_nxt      = FETCH_HI;
          end
        end
        default: state_nxt = FETCH_HI;
      endcase
    end
  end

endmodule
